// File: rtl/audio_i2s_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_serializer_pkg
// Brief    : Shared I2S framing constants and the mixer-to-PCM sample conversion.
// Revision : 1.0 - initial release
// ============================================================================
package audio_i2s_serializer_pkg;

    localparam int I2S_FRAME_BITS  = 64;
    localparam int I2S_SLOT_BITS   = 32;
    localparam int I2S_SAMPLE_BITS = 16;
    localparam int BIT_CNT_W       = $clog2(I2S_FRAME_BITS);

    // Offset-binary 9-bit to left-justified 16-bit two's complement.
    function automatic logic [I2S_SAMPLE_BITS-1:0] conv(input logic [8:0] x);
        return {~x[8], x[7:0], 7'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_i2s_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_serializer_if
// Brief    : Mixer sample inputs and I2S master outputs of the serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface audio_i2s_serializer_if;

    logic [8:0] left_in;
    logic [8:0] right_in;
    logic       mute;
    logic       i2s_bclk;
    logic       i2s_lrclk;
    logic       i2s_sdata;
    logic       sample_strobe;

    modport master (
        input  left_in, right_in, mute,
        output i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe
    );

    modport slave (
        output left_in, right_in, mute,
        input  i2s_bclk, i2s_lrclk, i2s_sdata, sample_strobe
    );

endinterface
`default_nettype wire

// File: rtl/audio_i2s_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_clkgen
// Brief    : Integer divider producing BCLK, a falling-edge strobe and bit count.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_clkgen
    import audio_i2s_serializer_pkg::*;
#(
    parameter int BCLK_HALF = 7
) (
    input  logic                 clk,
    input  logic                 mrst_n,
    output logic                 i2s_bclk,
    output logic                 bclk_fall,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    localparam int DIV_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 bclk_q, bclk_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 div_tc;

    assign div_tc = (div_cnt_q == DIV_TC);

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        bclk_d    = bclk_q;
        bit_cnt_d = bit_cnt_q;
        if (div_tc) begin
            div_cnt_d = '0;
            bclk_d    = ~bclk_q;
            if (bclk_q) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!mrst_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // High during the clk cycle whose closing edge drives BCLK 1->0.
    assign bclk_fall = div_tc & bclk_q;
    assign i2s_bclk  = bclk_q;
    assign bit_cnt   = bit_cnt_q;

endmodule
`default_nettype wire

// File: rtl/audio_i2s_serializer.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_serializer
// Brief    : Philips I2S master streaming 9-bit mixer samples as 16-bit PCM.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_serializer
    import audio_i2s_serializer_pkg::*;
#(
    parameter int BCLK_HALF = 7
) (
    input  logic                   clk,
    input  logic                   mrst_n,
    audio_i2s_serializer_if.master bus
);

    logic                       bclk;
    logic                       bclk_fall;
    logic [BIT_CNT_W-1:0]       bit_cnt;
    logic [BIT_CNT_W-1:0]       bit_nxt;
    logic [3:0]                 slot_idx;
    logic                       in_left_slot;
    logic                       in_right_slot;

    logic [I2S_SAMPLE_BITS-1:0] left_sh_q, left_sh_d;
    logic [I2S_SAMPLE_BITS-1:0] right_sh_q, right_sh_d;
    logic                       lrclk_q, lrclk_d;
    logic                       sdata_q, sdata_d;
    logic                       strobe_q, strobe_d;

    audio_i2s_clkgen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_clkgen (
        .clk       (clk),
        .mrst_n    (mrst_n),
        .i2s_bclk  (bclk),
        .bclk_fall (bclk_fall),
        .bit_cnt   (bit_cnt)
    );

    assign bit_nxt = bit_cnt + 1'b1;

    // Both slots start on a multiple of 16, so 16-n and 48-n reduce to -n mod 16.
    assign slot_idx      = 4'd0 - bit_nxt[3:0];
    assign in_left_slot  = (bit_nxt >= 6'd1) &&
                           (bit_nxt <= 6'(I2S_SAMPLE_BITS));
    assign in_right_slot = (bit_nxt >= 6'(I2S_SLOT_BITS + 1)) &&
                           (bit_nxt <= 6'(I2S_SLOT_BITS + I2S_SAMPLE_BITS));

    always_comb begin
        left_sh_d  = left_sh_q;
        right_sh_d = right_sh_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        strobe_d   = 1'b0;
        if (bclk_fall) begin
            if (bit_nxt == '0) begin
                left_sh_d  = bus.mute ? '0 : conv(bus.left_in);
                right_sh_d = bus.mute ? '0 : conv(bus.right_in);
                strobe_d   = 1'b1;
            end
            lrclk_d = bit_nxt[BIT_CNT_W-1];
            if (in_left_slot) begin
                sdata_d = left_sh_q[slot_idx];
            end else if (in_right_slot) begin
                sdata_d = right_sh_q[slot_idx];
            end else begin
                sdata_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!mrst_n) begin
            left_sh_q  <= '0;
            right_sh_q <= '0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            left_sh_q  <= left_sh_d;
            right_sh_q <= right_sh_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            strobe_q   <= strobe_d;
        end
    end

    assign bus.i2s_bclk      = bclk;
    assign bus.i2s_lrclk     = lrclk_q;
    assign bus.i2s_sdata     = sdata_q;
    assign bus.sample_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_i2s_serializer
// Brief    : Self-checking bench; a time-based frame model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_serializer;

    localparam int BH_A = 7;
    localparam int BH_B = 2;

    logic       clk = 1'b0;
    logic       mrst_n = 1'b0;
    logic [8:0] left_v = 9'h1FF;
    logic [8:0] right_v = 9'h000;
    logic       mute_v = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    audio_i2s_serializer_if if_a ();
    audio_i2s_serializer_if if_b ();

    assign if_a.left_in  = left_v;
    assign if_a.right_in = right_v;
    assign if_a.mute     = mute_v;
    assign if_b.left_in  = left_v;
    assign if_b.right_in = right_v;
    assign if_b.mute     = mute_v;

    audio_i2s_serializer #(.BCLK_HALF(BH_A)) dut_a (
        .clk    (clk),
        .mrst_n (mrst_n),
        .bus    (if_a)
    );

    audio_i2s_serializer #(.BCLK_HALF(BH_B)) dut_b (
        .clk    (clk),
        .mrst_n (mrst_n),
        .bus    (if_b)
    );

    // Signed value of the 9-bit offset sample, scaled to 16-bit full range.
    function automatic logic [15:0] pcm(input logic [8:0] x);
        int s;
        s = (int'(x) - 256) * 128;
        return s[15:0];
    endfunction

    function automatic logic [63:0] frame_of(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 16; i++) begin
            f[1 + i]  = l[15 - i];
            f[33 + i] = r[15 - i];
        end
        return f;
    endfunction

    // Expected {bclk, lrclk, sdata, strobe} after t clks since reset release.
    function automatic logic [3:0] model_out(input int unsigned t, input int bh,
                                             input logic [15:0] l, input logic [15:0] r);
        int unsigned n;
        logic b, lr, sd, st;
        n  = (t / (2 * bh)) % 64;
        b  = ((t / bh) % 2) == 1;
        lr = (n >= 32);
        sd = 1'b0;
        if (n >= 1 && n <= 16)       sd = l[16 - n];
        else if (n >= 33 && n <= 48) sd = r[48 - n];
        st = (t != 0) && (t % (128 * bh) == 0);
        return {b, lr, sd, st};
    endfunction

    int unsigned ta = 0, tb = 0;
    logic [15:0] la = '0, ra = '0, lb = '0, rb = '0;
    logic [3:0]  exp_a, exp_b, obs_a, obs_b;

    always @(posedge clk) begin
        if (!mrst_n) begin
            ta <= 0; la <= '0; ra <= '0;
            tb <= 0; lb <= '0; rb <= '0;
        end else begin
            ta <= ta + 1;
            tb <= tb + 1;
            if ((ta + 1) % (128 * BH_A) == 0) begin
                la <= mute_v ? 16'h0 : pcm(left_v);
                ra <= mute_v ? 16'h0 : pcm(right_v);
            end
            if ((tb + 1) % (128 * BH_B) == 0) begin
                lb <= mute_v ? 16'h0 : pcm(left_v);
                rb <= mute_v ? 16'h0 : pcm(right_v);
            end
        end
    end

    assign exp_a = model_out(ta, BH_A, la, ra);
    assign exp_b = model_out(tb, BH_B, lb, rb);
    assign obs_a = {if_a.i2s_bclk, if_a.i2s_lrclk, if_a.i2s_sdata, if_a.sample_strobe};
    assign obs_b = {if_b.i2s_bclk, if_b.i2s_lrclk, if_b.i2s_sdata, if_b.sample_strobe};

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs_a !== 4'b0000 || obs_b !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got a=%b b=%b exp 0000", i, obs_a, obs_b);
            end
        end
        mrst_n = 1'b1;
    endtask

    task automatic test_cold_start();
        logic [63:0] fr[2];
        int first_strobe;
        fr[0] = '0; fr[1] = '0;
        first_strobe = -1;
        for (int i = 0; i < 1792; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL cold_start ta=%0d got=%b exp=%b", ta, obs_a, exp_a);
            end
            if (first_strobe < 0 && if_a.sample_strobe) first_strobe = int'(ta);
            if (ta < 1792 && ta % 14 == 7) fr[ta / 896][(ta % 896) / 14] = if_a.i2s_sdata;
            if (ta == 1700) left_v = 9'h100;
        end
        n_chk++;
        if (first_strobe != 896) begin
            n_fail++;
            $display("FAIL first_strobe got=%0d exp=896", first_strobe);
        end
        n_chk++;
        if (fr[0] !== 64'h0) begin
            n_fail++;
            $display("FAIL first_frame_zero got=%h exp=0", fr[0]);
        end
        n_chk++;
        if (fr[1] !== frame_of(16'h7F80, 16'h8000)) begin
            n_fail++;
            $display("FAIL frame_7f80_8000 got=%h exp=%h", fr[1], frame_of(16'h7F80, 16'h8000));
        end
    endtask

    task automatic test_midframe_change();
        logic [63:0] fr[2];
        fr[0] = '0; fr[1] = '0;
        for (int i = 0; i < 1792; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL midframe ta=%0d got=%b exp=%b", ta, obs_a, exp_a);
            end
            if (ta >= 1792 && ta < 3584 && ta % 14 == 7)
                fr[ta / 896 - 2][(ta % 896) / 14] = if_a.i2s_sdata;
            if (ta == 1792 + 8 * 14 + 3) left_v = 9'h180;
        end
        n_chk++;
        if (fr[0] !== frame_of(16'h0000, 16'h8000)) begin
            n_fail++;
            $display("FAIL midframe_current got=%h exp=%h", fr[0], frame_of(16'h0000, 16'h8000));
        end
        n_chk++;
        if (fr[1] !== frame_of(16'h4000, 16'h8000)) begin
            n_fail++;
            $display("FAIL midframe_next got=%h exp=%h", fr[1], frame_of(16'h4000, 16'h8000));
        end
    endtask

    task automatic test_mute();
        logic [63:0] fr[3];
        logic [63:0] want[3];
        want[0] = frame_of(16'h4000, 16'h8000);
        want[1] = 64'h0;
        want[2] = frame_of(16'h7F80, 16'hC000);
        for (int k = 0; k < 3; k++) fr[k] = '0;
        for (int i = 0; i < 2688; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL mute ta=%0d got=%b exp=%b", ta, obs_a, exp_a);
            end
            if (ta >= 3584 && ta < 6272 && ta % 14 == 7)
                fr[ta / 896 - 4][(ta % 896) / 14] = if_a.i2s_sdata;
            if (ta == 3590) begin
                left_v  = 9'h1FF;
                right_v = 9'h080;
            end
            if (ta == 3584 + 40 * 14 + 3) mute_v = 1'b1;
            if (ta == 4580) mute_v = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (fr[k] !== want[k]) begin
                n_fail++;
                $display("FAIL mute_frame%0d got=%h exp=%h", k, fr[k], want[k]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] fr0;
        logic        prev_bclk;
        int          fall_k, strobe_k;
        fr0 = '0;
        fall_k = -1;
        strobe_k = -1;
        for (int i = 0; i < 283; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL pre_reset ta=%0d got=%b exp=%b", ta, obs_a, exp_a);
            end
        end
        mrst_n = 1'b0;
        @(negedge clk);
        mrst_n = 1'b1;
        n_chk++;
        if (obs_a !== 4'b0000 || obs_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL midframe_reset got a=%b b=%b exp 0000", obs_a, obs_b);
        end
        prev_bclk = if_a.i2s_bclk;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            n_chk++;
            if (obs_a !== exp_a) begin
                n_fail++;
                $display("FAIL post_reset ta=%0d got=%b exp=%b", ta, obs_a, exp_a);
            end
            if (fall_k < 0 && prev_bclk && !if_a.i2s_bclk) fall_k = k;
            if (strobe_k < 0 && if_a.sample_strobe) strobe_k = k;
            if (ta < 896 && ta % 14 == 7) fr0[ta / 14] = if_a.i2s_sdata;
            prev_bclk = if_a.i2s_bclk;
        end
        n_chk++;
        if (fall_k != 14) begin
            n_fail++;
            $display("FAIL first_bclk_fall got=%0d exp=14", fall_k);
        end
        n_chk++;
        if (strobe_k != 896) begin
            n_fail++;
            $display("FAIL restart_strobe got=%0d exp=896", strobe_k);
        end
        n_chk++;
        if (fr0 !== 64'h0) begin
            n_fail++;
            $display("FAIL restart_frame_zero got=%h exp=0", fr0);
        end
    endtask

    task automatic test_min_divider();
        logic [63:0] fr;
        int strobes;
        fr = '0;
        strobes = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs_b !== exp_b) begin
                n_fail++;
                $display("FAIL min_div tb=%0d got=%b exp=%b", tb, obs_b, exp_b);
            end
            if (if_b.sample_strobe) strobes++;
            if (tb >= 1024 && tb < 1280 && tb % 4 == 2) fr[(tb - 1024) / 4] = if_b.i2s_sdata;
        end
        n_chk++;
        if (strobes != 4) begin
            n_fail++;
            $display("FAIL min_div_strobes got=%0d exp=4", strobes);
        end
        n_chk++;
        if (fr !== frame_of(16'h7F80, 16'hC000)) begin
            n_fail++;
            $display("FAIL min_div_frame got=%h exp=%h", fr, frame_of(16'h7F80, 16'hC000));
        end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_midframe_change();
        test_mute();
        test_reset_midframe();
        test_min_divider();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_i2s_serializer.md
Name: audio_i2s_serializer

Overview:
- Downstream of the panner/mixer.
- Takes the mixer's 9-bit unsigned left/right samples and converts each to 16-bit two's complement.
- Streams them out as a standard Philips I2S master: BCLK, LRCLK, SDATA, 64 BCLK per frame.
- Drives the board's external audio codec/DAC. All timing is derived from the system clock by an integer divider.

Parameters:
- BCLK_HALF, 7, system clocks per BCLK half-period. Legal range ≥2. With clk=28 MHz: BCLK=2 MHz, fs=31.25 kHz.

Ports:
- clk  in  1  system clock
- mrst_n  in  1  reset, synchronous, active-low (sampled on rising clk)
- left_in  in  9  unsigned mixer output, left (midscale 9'h100)
- right_in  in  9  unsigned mixer output, right
- mute  in  1  forces latched samples to zero at next frame latch
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0=left slot, 1=right slot
- i2s_sdata  out  1  serial data, MSB first
- sample_strobe  out  1  one-clk pulse when a new stereo pair is latched

Behaviour:
- Reset (mrst_n=0 at a rising clk): next edge sets all outputs to 0, div_cnt=0, bit_cnt=0, both shadow samples=16'h0000. Reset mid-frame aborts the frame immediately; there is no partial-frame completion.
- Divider: div_cnt counts 0..BCLK_HALF-1. At terminal count it wraps to 0 and i2s_bclk toggles. BCLK period = 2*BCLK_HALF clks, 50% duty.
- Falling-edge event: the clk edge on which i2s_bclk goes 1->0.
  - bit_cnt (6 bits) increments mod 64.
  - i2s_lrclk, i2s_sdata and the shadows update on this same edge.
  - Receiver samples on the BCLK rising edge.
- i2s_lrclk = new bit_cnt[5]. Frame = 64 BCLK = 128*BCLK_HALF clks.
- Latch: on the falling-edge event where bit_cnt wraps 63->0:
  - left_sh <= mute ? 0 : conv(left_in); right_sh <= mute ? 0 : conv(right_in).
  - sample_strobe=1 for exactly that one clk.
  - Inputs are sampled only at this instant. Input changes mid-frame are not seen until the next latch.
- conv(x) = {~x[8], x[7:0], 7'b0}. Examples: 9'h100->16'h0000, 9'h1FF->16'h7F80, 9'h000->16'h8000, 9'h180->16'h4000.
- SDATA for new bit_cnt n (I2S one-BCLK delay after LRCLK change):
  - n in 1..16: left_sh[16-n]
  - n in 33..48: right_sh[48-n]
  - all other n: 0, including n=0 and n=32.
- First frame after reset carries zeros: the shadows are 0 and the first latch occurs at the first 63->0 wrap.
- First BCLK falling edge after reset release occurs 2*BCLK_HALF clks after release and yields bit_cnt=1.
- mute is synchronous and frame-granular; the current frame is never truncated.
- No handshake with the mixer. The mixer output is registered and free-running, so a sample-and-hold at the frame boundary is sufficient.

Decomposition:
- Shared include header (alongside config.vh) holds:
  - constants I2S_FRAME_BITS=64, I2S_SLOT_BITS=32, I2S_SAMPLE_BITS=16
  - the conv() function, reusable by any future PCM sink (S/PDIF, HDMI audio)
- One sub-module, audio_i2s_clkgen:
  - owns div_cnt and i2s_bclk
  - emits a one-clk bclk_fall pulse and bit_cnt
- The top module owns the shadow registers, latch, sample_strobe and the sdata mux/shift logic.

Test Plan:
- Release reset, BCLK_HALF=7, inputs 9'h1FF -> i2s_bclk period 14 clk; i2s_lrclk period 896 clk. First frame sdata all 0. First sample_strobe at clk 896 after release, then every 896.
- left_in=9'h1FF, right_in=9'h000 held -> second frame: left slot bits 1..16 = 0x7F80 MSB-first; right slot bits 33..48 = 0x8000; bits 0, 17..32, 49..63 = 0.
- left_in=9'h100 -> slot word 0x0000. Change left_in to 9'h180 at bit_cnt=8 -> current frame unchanged; next frame left word 0x4000.
- Assert mute at bit_cnt=40 with nonzero inputs -> remainder of current frame unchanged; next frame both slots 0x0000. Deassert mute -> following frame restores data.
- Assert mrst_n=0 at bit_cnt=20 for one clk -> next edge all outputs 0, shadows 0. After release, timing is identical to the cold start case (first bclk fall at +14 clk).
- BCLK_HALF=2 -> BCLK period 4 clk, frame 256 clk, data correct (minimum divider boundary).
